// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution / pooling pipeline.
package conv_pkg;

    localparam int BITWIDTH     = 8;
    localparam int FILTER_WIDTH = 3;

    typedef logic [BITWIDTH-1:0] pixel_t;

    // Flattened window element index: row r (0 = oldest), column c (0 = leftmost).
    function automatic int win_idx(input int r, input int c, input int fw);
        return r * fw + c;
    endfunction

endpackage

// File: rtl/row_delay_line.sv
// One image row of delay: an enable-gated shift register DEPTH pixels deep.
module row_delay_line
    import conv_pkg::*;
#(
    parameter int  DEPTH      = 8,
    parameter type pixel_type = pixel_t
) (
    input  logic      clock,
    input  logic      enable,
    input  pixel_type din,
    output pixel_type dout
);

    pixel_type mem_q [DEPTH];
    pixel_type mem_d [DEPTH];

    // Shift one position per accepted pixel; hold otherwise.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        mem_d = mem_q;
        if (enable) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Storage register.
    always_ff @(posedge clock) begin
        // NOTE: pixel storage has no reset; stale contents are always flushed before
        // they can reach a valid window, and skipping the reset keeps the array small.
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/window_line_buffer.sv
// Raster stream -> filterWidth x filterWidth sliding window (stride 1, valid windows only).
module window_line_buffer
    import conv_pkg::*;
#(
    parameter int bitwidth    = BITWIDTH,
    parameter int filterWidth = FILTER_WIDTH,
    parameter int imageWidth  = 8,
    parameter int imageHeight = 8
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [bitwidth-1:0]                       data_in,
    input  logic                                      isValid,
    output logic [filterWidth*filterWidth*bitwidth-1:0] window_out,
    output logic                                      window_valid,
    output logic                                      frame_done
);

    localparam int FW = filterWidth;
    localparam int CW = $clog2(imageWidth);
    localparam int RW = $clog2(imageHeight);

    typedef logic [bitwidth-1:0] px_t;

    logic          accept;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last, row_last;
    logic          window_valid_q, window_valid_d;
    logic          frame_done_q, frame_done_d;
    px_t           win_q [FW][FW];
    px_t           win_d [FW][FW];
    px_t           taps  [FW-1];

    // Reset wins over a simultaneous valid pixel.
    assign accept   = isValid && !reset;
    assign col_last = (col_q == CW'(imageWidth - 1));
    assign row_last = (row_q == RW'(imageHeight - 1));

    // Cascaded row delays: taps[0] is one row back, taps[FW-2] is the oldest row.
    for (genvar g = 0; g < FW - 1; g++) begin : g_line
        px_t line_in;
        if (g == 0) begin : g_head
            assign line_in = data_in;
        end else begin : g_chain
            assign line_in = taps[g-1];
        end
        row_delay_line #(
            .DEPTH      (imageWidth),
            .pixel_type (px_t)
        ) u_line (
            .clock  (clock),
            .enable (accept),
            .din    (line_in),
            .dout   (taps[g])
        );
    end

    // Next-state: window shift, raster counters and the registered status flags.
    always_comb begin
        win_d          = win_q;
        col_d          = col_q;
        row_d          = row_q;
        window_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        if (accept) begin
            for (int r = 0; r < FW; r++) begin
                for (int c = 0; c < FW - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < FW - 1; r++) begin
                win_d[r][FW-1] = taps[FW-2-r];
            end
            win_d[FW-1][FW-1] = data_in;

            // The column gate rejects row-straddling windows, the row gate cross-frame ones.
            window_valid_d = (row_q >= RW'(FW - 1)) && (col_q >= CW'(FW - 1));
            frame_done_d   = col_last && row_last;

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            col_q          <= '0;
            row_q          <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            win_q          <= '{default: '0};
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
            win_q          <= win_d;
        end
    end

    // Flatten the window registers into the output bus.
    always_comb begin
        window_out = '0;
        for (int r = 0; r < FW; r++) begin
            for (int c = 0; c < FW; c++) begin
                window_out[win_idx(r, c, FW)*bitwidth +: bitwidth] = win_q[r][c];
            end
        end
    end

    assign window_valid = window_valid_q;
    assign frame_done   = frame_done_q;

endmodule
